// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, encodings, decode table.
package id_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned CMD_W     = 4;
    localparam int unsigned BR_W      = 2;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned PC_W      = 32;

    // Opcode map
    localparam logic [OPC_W-1:0] OPC_NOP  = 6'h00;
    localparam logic [OPC_W-1:0] OPC_ADD  = 6'h01;
    localparam logic [OPC_W-1:0] OPC_SUB  = 6'h02;
    localparam logic [OPC_W-1:0] OPC_AND  = 6'h03;
    localparam logic [OPC_W-1:0] OPC_OR   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_XOR  = 6'h05;
    localparam logic [OPC_W-1:0] OPC_SLT  = 6'h06;
    localparam logic [OPC_W-1:0] OPC_ADDI = 6'h10;
    localparam logic [OPC_W-1:0] OPC_ANDI = 6'h11;
    localparam logic [OPC_W-1:0] OPC_ORI  = 6'h12;
    localparam logic [OPC_W-1:0] OPC_LW   = 6'h13;
    localparam logic [OPC_W-1:0] OPC_SW   = 6'h14;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 6'h15;
    localparam logic [OPC_W-1:0] OPC_BNE  = 6'h16;
    localparam logic [OPC_W-1:0] OPC_JMP  = 6'h17;

    typedef enum logic [CMD_W-1:0] {
        EXE_NOP = 4'd0,
        EXE_ADD = 4'd1,
        EXE_SUB = 4'd2,
        EXE_AND = 4'd3,
        EXE_OR  = 4'd4,
        EXE_XOR = 4'd5,
        EXE_SLT = 4'd6
    } exe_cmd_e;

    typedef enum logic [BR_W-1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    typedef struct packed {
        exe_cmd_e exe_cmd;
        logic     mem_write;
        logic     mem_read;
        br_type_e br_type;
        logic     wb_en;
        logic     is_imm;
    } dec_t;

    localparam dec_t DEC_NOP = '{
        exe_cmd:   EXE_NOP,
        mem_write: 1'b0,
        mem_read:  1'b0,
        br_type:   BR_NONE,
        wb_en:     1'b0,
        is_imm:    1'b0
    };

    // Opcode -> control fields; anything unlisted decodes as a NOP
    function automatic dec_t decode(input logic [OPC_W-1:0] opc);
        dec_t d;
        d = DEC_NOP;
        case (opc)
            OPC_ADD:  begin d.exe_cmd = EXE_ADD; d.wb_en = 1'b1; end
            OPC_SUB:  begin d.exe_cmd = EXE_SUB; d.wb_en = 1'b1; end
            OPC_AND:  begin d.exe_cmd = EXE_AND; d.wb_en = 1'b1; end
            OPC_OR:   begin d.exe_cmd = EXE_OR;  d.wb_en = 1'b1; end
            OPC_XOR:  begin d.exe_cmd = EXE_XOR; d.wb_en = 1'b1; end
            OPC_SLT:  begin d.exe_cmd = EXE_SLT; d.wb_en = 1'b1; end
            OPC_ADDI: begin d.exe_cmd = EXE_ADD; d.wb_en = 1'b1; d.is_imm = 1'b1; end
            OPC_ANDI: begin d.exe_cmd = EXE_AND; d.wb_en = 1'b1; d.is_imm = 1'b1; end
            OPC_ORI:  begin d.exe_cmd = EXE_OR;  d.wb_en = 1'b1; d.is_imm = 1'b1; end
            OPC_LW:   begin d.exe_cmd = EXE_ADD; d.wb_en = 1'b1; d.mem_read = 1'b1; d.is_imm = 1'b1; end
            OPC_SW:   begin d.exe_cmd = EXE_ADD; d.mem_write = 1'b1; d.is_imm = 1'b1; end
            OPC_BEQ:  begin d.exe_cmd = EXE_SUB; d.br_type = BR_BEQ; d.is_imm = 1'b1; end
            OPC_BNE:  begin d.exe_cmd = EXE_SUB; d.br_type = BR_BNE; d.is_imm = 1'b1; end
            OPC_JMP:  begin d.br_type = BR_JMP; d.is_imm = 1'b1; end
            default:  d = DEC_NOP;
        endcase
        return d;
    endfunction

    // Nonzero source index matching a downstream destination
    function automatic logic src_hit(input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two async read ports, one write port, write-through.
module id_regfile
    import id_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [REG_IDX_W-1:0] i_rd_addr1,
    input  logic [REG_IDX_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0]    o_rd_data1,
    output logic [DATA_W-1:0]    o_rd_data2,
    input  logic                 i_wr_en,
    input  logic [REG_IDX_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]    i_wr_data
);

    localparam int unsigned AW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    logic [DATA_W-1:0] r_regs [REG_CNT];
    logic              w_wr_ok;

    // r0 and indices past the implemented range are hardwired to zero
    function automatic logic in_range(input logic [REG_IDX_W-1:0] a);
        return (a != '0) && (32'(a) < REG_CNT);
    endfunction

    assign w_wr_ok = i_wr_en && in_range(i_wr_addr);

    // Register storage, written on the rising edge regardless of pipeline stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr[AW-1:0]] <= i_wr_data;
        end
    end

    // Read port 1 with write-through bypass
    always_comb begin
        o_rd_data1 = '0;
        if (in_range(i_rd_addr1)) begin
            if (w_wr_ok && (i_wr_addr == i_rd_addr1)) begin
                o_rd_data1 = i_wr_data;
            end else begin
                o_rd_data1 = r_regs[i_rd_addr1[AW-1:0]];
            end
        end
    end

    // Read port 2 with write-through bypass
    always_comb begin
        o_rd_data2 = '0;
        if (in_range(i_rd_addr2)) begin
            if (w_wr_ok && (i_wr_addr == i_rd_addr2)) begin
                o_rd_data2 = i_wr_data;
            end else begin
                o_rd_data2 = r_regs[i_rd_addr2[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: decode, operand fetch, RAW hazard detection, ID/EXE register.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_CNT    = 32,
    parameter int unsigned FORWARD_EN = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [INSTR_W-1:0]   i_instruction,
    input  logic [PC_W-1:0]      i_pc_in,
    input  logic                 i_if_valid,
    input  logic                 i_flush,
    input  logic                 i_wb_en,
    input  logic [REG_IDX_W-1:0] i_wb_dest,
    input  logic [DATA_W-1:0]    i_wb_data,
    input  logic [REG_IDX_W-1:0] i_exe_dest,
    input  logic [REG_IDX_W-1:0] i_mem_dest,
    input  logic                 i_exe_wb_en,
    input  logic                 i_mem_wb_en,
    input  logic                 i_exe_mem_read,
    output logic                 o_hazard_stall,
    output logic [CMD_W-1:0]     o_exe_cmd,
    output logic                 o_mem_write,
    output logic                 o_mem_read,
    output logic [BR_W-1:0]      o_br_type,
    output logic                 o_wb_en_out,
    output logic [DATA_W-1:0]    o_val1,
    output logic [DATA_W-1:0]    o_val2,
    output logic [DATA_W-1:0]    o_reg2,
    output logic [REG_IDX_W-1:0] o_dest,
    output logic [REG_IDX_W-1:0] o_src1_out,
    output logic [REG_IDX_W-1:0] o_src2_out,
    output logic [PC_W-1:0]      o_pc_out,
    output logic                 o_valid_out
);

    logic [OPC_W-1:0]     w_opc;
    logic [REG_IDX_W-1:0] w_src1;
    logic [REG_IDX_W-1:0] w_src2;
    logic [REG_IDX_W-1:0] w_rd;
    logic [IMM_W-1:0]     w_imm;
    logic [DATA_W-1:0]    w_imm_ext;
    dec_t                 w_dec;
    logic [DATA_W-1:0]    w_rdata1;
    logic [DATA_W-1:0]    w_rdata2;
    logic                 w_src2_used;
    logic                 w_hit_exe;
    logic                 w_hit_mem;
    logic                 w_stall;
    logic                 w_bubble;

    logic [CMD_W-1:0]     r_exe_cmd;
    logic                 r_mem_write;
    logic                 r_mem_read;
    logic [BR_W-1:0]      r_br_type;
    logic                 r_wb_en;
    logic [DATA_W-1:0]    r_val1;
    logic [DATA_W-1:0]    r_val2;
    logic [DATA_W-1:0]    r_reg2;
    logic [REG_IDX_W-1:0] r_dest;
    logic [REG_IDX_W-1:0] r_src1;
    logic [REG_IDX_W-1:0] r_src2;
    logic [PC_W-1:0]      r_pc;
    logic                 r_valid;

    assign w_opc     = i_instruction[31:26];
    assign w_src1    = i_instruction[25:21];
    assign w_src2    = i_instruction[20:16];
    assign w_rd      = i_instruction[15:11];
    assign w_imm     = i_instruction[15:0];
    assign w_imm_ext = DATA_W'($signed(w_imm));
    assign w_dec     = decode(w_opc);

    id_regfile #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_addr1 (w_src1),
        .i_rd_addr2 (w_src2),
        .o_rd_data1 (w_rdata1),
        .o_rd_data2 (w_rdata2),
        .i_wr_en    (i_wb_en),
        .i_wr_addr  (i_wb_dest),
        .i_wr_data  (i_wb_data)
    );

    // RAW hazard: load-use only with forwarding, any pending write without it
    always_comb begin
        w_src2_used = !w_dec.is_imm || w_dec.mem_write || (w_dec.br_type != BR_NONE);
        w_hit_exe   = src_hit(w_src1, i_exe_dest) || (w_src2_used && src_hit(w_src2, i_exe_dest));
        w_hit_mem   = src_hit(w_src1, i_mem_dest) || (w_src2_used && src_hit(w_src2, i_mem_dest));
        if (FORWARD_EN != 0) begin
            w_stall = i_if_valid && i_exe_mem_read && w_hit_exe;
        end else begin
            w_stall = i_if_valid && ((i_exe_wb_en && w_hit_exe) || (i_mem_wb_en && w_hit_mem));
        end
    end

    assign o_hazard_stall = w_stall;
    assign w_bubble       = i_flush || w_stall || !i_if_valid;

    // ID/EXE pipeline register; flush, stall or empty fetch inject a bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exe_cmd   <= EXE_NOP;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_br_type   <= BR_NONE;
            r_wb_en     <= 1'b0;
            r_val1      <= '0;
            r_val2      <= '0;
            r_reg2      <= '0;
            r_dest      <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_pc        <= '0;
            r_valid     <= 1'b0;
        end else if (w_bubble) begin
            r_exe_cmd   <= DEC_NOP.exe_cmd;
            r_mem_write <= DEC_NOP.mem_write;
            r_mem_read  <= DEC_NOP.mem_read;
            r_br_type   <= DEC_NOP.br_type;
            r_wb_en     <= DEC_NOP.wb_en;
            r_val1      <= '0;
            r_val2      <= '0;
            r_reg2      <= '0;
            r_dest      <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_pc        <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_exe_cmd   <= w_dec.exe_cmd;
            r_mem_write <= w_dec.mem_write;
            r_mem_read  <= w_dec.mem_read;
            r_br_type   <= w_dec.br_type;
            r_wb_en     <= w_dec.wb_en;
            r_val1      <= w_rdata1;
            r_val2      <= w_dec.is_imm ? w_imm_ext : w_rdata2;
            r_reg2      <= w_rdata2;
            r_dest      <= w_dec.is_imm ? w_src2 : w_rd;
            r_src1      <= w_src1;
            r_src2      <= w_src2;
            r_pc        <= i_pc_in;
            r_valid     <= 1'b1;
        end
    end

    assign o_exe_cmd   = r_exe_cmd;
    assign o_mem_write = r_mem_write;
    assign o_mem_read  = r_mem_read;
    assign o_br_type   = r_br_type;
    assign o_wb_en_out = r_wb_en;
    assign o_val1      = r_val1;
    assign o_val2      = r_val2;
    assign o_reg2      = r_reg2;
    assign o_dest      = r_dest;
    assign o_src1_out  = r_src1;
    assign o_src2_out  = r_src2;
    assign o_pc_out    = r_pc;
    assign o_valid_out = r_valid;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboarded bench for id_stage_pipe: two configurations share one stimulus stream.
`timescale 1ns/1ps
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        ifv, flush, wbe, exwb, mewb, exmr;
    logic [4:0]  wbd, exd, med;
    logic [31:0] wbdata;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic        wb;
        logic        mw;
        logic        mr;
        logic [1:0]  br;
        logic [3:0]  cmd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] r2;
        logic [4:0]  dest;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] pc;
    } exp_t;

    // DUT 0: forwarding, full register file. DUT 1: no forwarding, 16 registers.
    logic        o0_stall, o0_mw, o0_mr, o0_wb, o0_valid;
    logic [3:0]  o0_cmd;
    logic [1:0]  o0_br;
    logic [31:0] o0_v1, o0_v2, o0_r2, o0_pc;
    logic [4:0]  o0_dest, o0_s1, o0_s2;
    logic        o1_stall, o1_mw, o1_mr, o1_wb, o1_valid;
    logic [3:0]  o1_cmd;
    logic [1:0]  o1_br;
    logic [31:0] o1_v1, o1_v2, o1_r2, o1_pc;
    logic [4:0]  o1_dest, o1_s1, o1_s2;

    id_stage_pipe #(.DATA_W(32), .REG_CNT(32), .FORWARD_EN(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instruction(instr), .i_pc_in(pc_in),
        .i_if_valid(ifv), .i_flush(flush), .i_wb_en(wbe), .i_wb_dest(wbd), .i_wb_data(wbdata),
        .i_exe_dest(exd), .i_mem_dest(med), .i_exe_wb_en(exwb), .i_mem_wb_en(mewb),
        .i_exe_mem_read(exmr), .o_hazard_stall(o0_stall), .o_exe_cmd(o0_cmd),
        .o_mem_write(o0_mw), .o_mem_read(o0_mr), .o_br_type(o0_br), .o_wb_en_out(o0_wb),
        .o_val1(o0_v1), .o_val2(o0_v2), .o_reg2(o0_r2), .o_dest(o0_dest),
        .o_src1_out(o0_s1), .o_src2_out(o0_s2), .o_pc_out(o0_pc), .o_valid_out(o0_valid)
    );

    id_stage_pipe #(.DATA_W(32), .REG_CNT(16), .FORWARD_EN(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instruction(instr), .i_pc_in(pc_in),
        .i_if_valid(ifv), .i_flush(flush), .i_wb_en(wbe), .i_wb_dest(wbd), .i_wb_data(wbdata),
        .i_exe_dest(exd), .i_mem_dest(med), .i_exe_wb_en(exwb), .i_mem_wb_en(mewb),
        .i_exe_mem_read(exmr), .o_hazard_stall(o1_stall), .o_exe_cmd(o1_cmd),
        .o_mem_write(o1_mw), .o_mem_read(o1_mr), .o_br_type(o1_br), .o_wb_en_out(o1_wb),
        .o_val1(o1_v1), .o_val2(o1_v2), .o_reg2(o1_r2), .o_dest(o1_dest),
        .o_src1_out(o1_s1), .o_src2_out(o1_s2), .o_pc_out(o1_pc), .o_valid_out(o1_valid)
    );

    int checks   = 0;
    int failures = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mregs [2][32];
    int          rcnt [2] = '{32, 16};
    int          fwd  [2] = '{1, 0};

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h expected=%h t=%0t", nm, d, got, exp, $time);
        end
    endtask

    // Opcode table from the instruction-set definition: cmd, mem_write, mem_read, br, wb, is_imm
    function automatic void ref_decode(input logic [5:0] op, output logic [3:0] cmd, output logic mw,
                                       output logic mr, output logic [1:0] br, output logic wb,
                                       output logic imm);
        cmd = 0; mw = 0; mr = 0; br = 0; wb = 0; imm = 0;
        case (op)
            6'h01: begin cmd = 1; wb = 1; end
            6'h02: begin cmd = 2; wb = 1; end
            6'h03: begin cmd = 3; wb = 1; end
            6'h04: begin cmd = 4; wb = 1; end
            6'h05: begin cmd = 5; wb = 1; end
            6'h06: begin cmd = 6; wb = 1; end
            6'h10: begin cmd = 1; wb = 1; imm = 1; end
            6'h11: begin cmd = 3; wb = 1; imm = 1; end
            6'h12: begin cmd = 4; wb = 1; imm = 1; end
            6'h13: begin cmd = 1; wb = 1; mr = 1; imm = 1; end
            6'h14: begin cmd = 1; mw = 1; imm = 1; end
            6'h15: begin cmd = 2; br = 1; imm = 1; end
            6'h16: begin cmd = 2; br = 2; imm = 1; end
            6'h17: begin br = 3; imm = 1; end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rread(input int d, input logic [4:0] a);
        if (a == 0 || int'(a) >= rcnt[d]) return 32'h0;
        if (wbe && wbd == a) return wbdata;
        return mregs[d][a];
    endfunction

    function automatic logic hit(input logic [4:0] s, input logic [4:0] t);
        return (s != 0) && (s == t);
    endfunction

    // Reference: expected stall now and expected ID/EXE contents after the next edge
    task automatic model_push();
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            logic [3:0] cmd; logic mw, mr, wb, imm; logic [1:0] br;
            logic [4:0] s1, s2;
            logic used2, he, hm, st;
            ref_decode(instr[31:26], cmd, mw, mr, br, wb, imm);
            s1 = instr[25:21];
            s2 = instr[20:16];
            used2 = !imm || mw || (br != 0);
            he = hit(s1, exd) || (used2 && hit(s2, exd));
            hm = hit(s1, med) || (used2 && hit(s2, med));
            if (fwd[d] != 0) st = ifv && exmr && he;
            else             st = ifv && ((exwb && he) || (mewb && hm));
            e = '0;
            e.stall = st;
            if (!(flush || st || !ifv)) begin
                e.valid = 1; e.wb = wb; e.mw = mw; e.mr = mr; e.br = br; e.cmd = cmd;
                e.v1 = rread(d, s1);
                e.r2 = rread(d, s2);
                e.v2 = imm ? {{16{instr[15]}}, instr[15:0]} : e.r2;
                e.dest = imm ? s2 : instr[15:11];
                e.s1 = s1; e.s2 = s2; e.pc = pc_in;
            end
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        for (int d = 0; d < 2; d++) begin
            if (wbe && wbd != 0 && int'(wbd) < rcnt[d]) mregs[d][wbd] = wbdata;
        end
    endtask

    task automatic compare(input int d, input exp_t g, input exp_t e);
        chk("hazard_stall", d, 32'(g.stall), 32'(e.stall));
        chk("valid_out", d, 32'(g.valid), 32'(e.valid));
        chk("wb_en_out", d, 32'(g.wb), 32'(e.wb));
        chk("mem_write", d, 32'(g.mw), 32'(e.mw));
        chk("mem_read", d, 32'(g.mr), 32'(e.mr));
        chk("br_type", d, 32'(g.br), 32'(e.br));
        chk("exe_cmd", d, 32'(g.cmd), 32'(e.cmd));
        if (e.valid) begin
            chk("val1", d, g.v1, e.v1);
            chk("val2", d, g.v2, e.v2);
            chk("reg2", d, g.r2, e.r2);
            chk("dest", d, 32'(g.dest), 32'(e.dest));
            chk("src1_out", d, 32'(g.s1), 32'(e.s1));
            chk("src2_out", d, 32'(g.s2), 32'(e.s2));
            chk("pc_out", d, g.pc, e.pc);
        end
    endtask

    function automatic exp_t obs(input int d);
        exp_t g;
        if (d == 0) g = '{o0_stall, o0_valid, o0_wb, o0_mw, o0_mr, o0_br, o0_cmd, o0_v1, o0_v2,
                          o0_r2, o0_dest, o0_s1, o0_s2, o0_pc};
        else        g = '{o1_stall, o1_valid, o1_wb, o1_mw, o1_mr, o1_br, o1_cmd, o1_v1, o1_v2,
                          o1_r2, o1_dest, o1_s1, o1_s2, o1_pc};
        return g;
    endfunction

    // Monitor: one expected entry per DUT per captured cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) compare(0, obs(0), q0.pop_front());
            if (q1.size() > 0) compare(1, obs(1), q1.pop_front());
        end
    end

    task automatic step(input logic [31:0] ins, input logic v, input logic fl,
                        input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                        input logic [4:0] ed, input logic [4:0] md,
                        input logic ewb, input logic mwb, input logic emr);
        @(negedge clk);
        instr = ins; ifv = v; flush = fl; wbe = we; wbd = wd; wbdata = wdat;
        exd = ed; med = md; exwb = ewb; mewb = mwb; exmr = emr;
        pc_in = pc_in + 32'd4;
        #1;
        model_push();
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [15:0] lo);
        return {op, s1, s2, lo};
    endfunction

    function automatic logic [15:0] rdf(input logic [4:0] rd);
        return {rd, 11'h0};
    endfunction

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input int d);
        exp_t g;
        g = obs(d);
        chk("reset_outputs", d, 32'(g[$bits(exp_t)-2:0] != 0), 32'd0);
        chk("reset_valid", d, 32'(g.valid), 32'd0);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) mregs[d][r] = 32'h0;
    endtask

    logic [5:0] ops [15] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h10,
                             6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17};

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 4) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 9));
    endfunction

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic [5:0] op;
            int sel;
            sel = int'($urandom_range(0, 17));
            op  = (sel < 15) ? ops[sel] : 6'($urandom);
            step(mk(op, rreg(), rreg(), 16'($urandom)), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom), rreg(), $urandom,
                 rreg(), rreg(), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; instr = '0; pc_in = 32'h100; ifv = 0; flush = 0; wbe = 0; wbd = 0;
        wbdata = 0; exd = 0; med = 0; exwb = 0; mewb = 0; exmr = 0;
        clear_model();
        #2;
        check_all_zero(0);
        check_all_zero(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // r3 = 0x1234, then ADD r5,r3,r3
        step(32'h0, 0, 0, 1, 5'd3, 32'h1234, 0, 0, 0, 0, 0);
        step(mk(6'h01, 5'd3, 5'd3, rdf(5'd5)), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("add_val1", 0, o0_v1, 32'h1234);
        chk("add_val2", 0, o0_v2, 32'h1234);
        chk("add_dest", 0, 32'(o0_dest), 32'd5);
        chk("add_valid", 0, 32'(o0_valid), 32'd1);

        // ADDI r4,r3,0xFFFF
        step(mk(6'h10, 5'd3, 5'd4, 16'hFFFF), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("addi_val2", 0, o0_v2, 32'hFFFF_FFFF);
        chk("addi_dest", 0, 32'(o0_dest), 32'd4);

        // r0 ignores writes
        step(32'h0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        step(mk(6'h01, 5'd0, 5'd0, rdf(5'd1)), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("r0_read", 0, o0_v1, 32'h0);

        // Load-use with forwarding stalls; without a load it does not
        step(mk(6'h01, 5'd3, 5'd2, rdf(5'd6)), 1, 0, 0, 0, 0, 5'd3, 0, 1, 0, 1);
        after_edge();
        chk("loaduse_stall", 0, 32'(o0_stall), 32'd1);
        chk("loaduse_bubble", 0, 32'(o0_valid), 32'd0);
        step(mk(6'h01, 5'd3, 5'd2, rdf(5'd6)), 1, 0, 0, 0, 0, 5'd3, 0, 1, 0, 0);
        after_edge();
        chk("noload_nostall", 0, 32'(o0_stall), 32'd0);
        chk("noload_valid", 0, 32'(o0_valid), 32'd1);

        // No forwarding: MEM writer of r7 blocks src2; r0 never blocks
        step(mk(6'h01, 5'd1, 5'd7, rdf(5'd8)), 1, 0, 0, 0, 0, 0, 5'd7, 0, 1, 0);
        after_edge();
        chk("memraw_stall", 1, 32'(o1_stall), 32'd1);
        chk("memraw_bubble", 1, 32'(o1_valid), 32'd0);
        step(mk(6'h01, 5'd0, 5'd0, rdf(5'd8)), 1, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0);
        after_edge();
        chk("r0_nostall", 1, 32'(o1_stall), 32'd0);
        chk("r0_valid", 1, 32'(o1_valid), 32'd1);

        // Flush beats stall; same-cycle write to r9 is visible to the read
        step(mk(6'h01, 5'd9, 5'd3, rdf(5'd2)), 1, 1, 1, 5'd9, 32'hCAFE, 5'd9, 0, 1, 0, 1);
        after_edge();
        chk("flush_stall_out", 0, 32'(o0_stall), 32'd1);
        chk("flush_valid", 0, 32'(o0_valid), 32'd0);
        chk("flush_wb", 0, 32'(o0_wb), 32'd0);
        step(mk(6'h01, 5'd9, 5'd9, rdf(5'd2)), 1, 0, 1, 5'd9, 32'hBEEF, 0, 0, 0, 0, 0);
        after_edge();
        chk("wthru_r9", 0, o0_v1, 32'hBEEF);

        // r20 exists only in the 32-entry file
        step(32'h0, 0, 0, 1, 5'd20, 32'h5555, 0, 0, 0, 0, 0);
        step(mk(6'h01, 5'd20, 5'd20, rdf(5'd1)), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("r20_small", 1, o1_v1, 32'h0);
        chk("r20_full", 0, o0_v1, 32'h5555);

        random_steps(400);

        // Asynchronous reset with a valid instruction in the register and a stall pending
        step(mk(6'h01, 5'd3, 5'd3, rdf(5'd5)), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        instr = mk(6'h01, 5'd3, 5'd3, rdf(5'd5)); exd = 5'd3; exmr = 1; exwb = 1; ifv = 1; wbe = 0;
        rst_n = 1'b0;
        #1;
        check_all_zero(0);
        check_all_zero(1);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(mk(6'h01, 5'd3, 5'd3, rdf(5'd5)), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        random_steps(100);

        repeat (3) @(posedge clk);
        #2;
        chk("q0_drained", 0, 32'(q0.size()), 32'd0);
        chk("q1_drained", 1, 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
